mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have: ex_mul_valid  in  1  multiply instruction present in EX.
REQ-004 SHALL have: ex_mul_sign  in  1  1 = signed (MULT/MUL), 0 = unsigned (MULTU).
REQ-005 SHALL have: ex_mul_to_gpr  in  1  1 = MUL (low word to GPR), 0 = MULT/MULTU (to HI/LO).
REQ-006 SHALL have: ex_src1, ex_src2  in  32 each  operands; ex_dest  in  5  GPR destination.
REQ-007 SHALL have: flush  in  1  kill the EX instruction.
REQ-008 SHALL have: hi_we_i, lo_we_i  in  1 each; hilo_wdata_i  in  32  MTHI/MTLO write.
REQ-009 SHALL have: mul_start_o  out  1; mul_sign_o  out  1; mul_op1_o, mul_op2_o  out  32 each; all to multiplier.
REQ-010 SHALL have: mul_ready_i  in  1; mul_result_i  in  64; from multiplier.
REQ-011 SHALL have: stall_o  out  1  hold EX and upstream.
REQ-012 SHALL have: hi_o, lo_o  out  32 each  architectural HI/LO.
REQ-013 SHALL have: gpr_we_o  out  1; gpr_waddr_o  out  5; gpr_wdata_o  out  32.

Function
REQ-014 States SHALL be IDLE, BUSY, REL; encoding free.
REQ-015 IDLE: ex_mul_valid & !flush -> latch src1/src2/sign/to_gpr/dest, mul_start_o <= 1, go BUSY; else stay IDLE.
REQ-016 mul_op1_o/op2_o/sign_o SHALL come from the latched registers and stay constant from accept until leaving BUSY.
REQ-017 mul_start_o SHALL be registered, high exactly during BUSY, low in IDLE and REL.
REQ-018 BUSY & mul_ready_i & !flush: capture mul_result_i that cycle, commit (REQ-021/022), go REL.
REQ-019 Multiplier contract: ready rises 7 cycles after start first seen high; result valid only in the first ready cycle; start must drop for at least one cycle to rearm; the capture SHALL use the first ready cycle.
REQ-020 REL: mul_start_o low one cycle, unconditionally go IDLE; no acceptance in REL.
REQ-021 to_gpr = 0: hi_o <= result[63:32], lo_o <= result[31:0] on the capture edge.
REQ-022 to_gpr = 1: gpr_we_o pulses one cycle after capture, gpr_wdata_o = result[31:0], gpr_waddr_o = dest; HI/LO unchanged; dest = 0 -> gpr_we_o stays 0.
REQ-023 stall_o (combinational) = (IDLE & ex_mul_valid & !flush) | (BUSY & !mul_ready_i & !flush) | (REL & ex_mul_valid).
REQ-024 Latency: accept cycle plus 7 BUSY cycles stalled (8 total); EX advances in the 9th cycle (ready cycle).
REQ-025 Flush in BUSY (any cycle, incl. ready cycle): no HI/LO or GPR write, mul_start_o <= 0, go REL.
REQ-026 hi_we_i/lo_we_i SHALL write hilo_wdata_i to HI/LO on the next edge in any state.
REQ-027 The same edge's HI/LO commit SHALL win over hi_we_i/lo_we_i to the same register.
REQ-028 gpr_waddr_o/gpr_wdata_o SHALL read 0 whenever gpr_we_o = 0.

Reset
REQ-029 resetn low SHALL immediately force: state IDLE, mul_start_o 0, mul_sign_o 0, mul_op1_o/op2_o 0, hi_o/lo_o 0, gpr_we_o/waddr/wdata 0.
REQ-030 stall_o SHALL be 0 during reset regardless of inputs.
REQ-031 Reset mid-BUSY SHALL abandon the operation with no commit.
REQ-032 The first accept after reset release SHALL behave as from IDLE.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high 8 cycles; HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-034 MULT -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
REQ-035 MUL 7 x 6, dest 5 -> one gpr_we_o pulse, waddr 5, wdata 42; HI/LO unchanged.
REQ-036 MUL 7 x 6, dest 0 -> no gpr_we_o pulse.
REQ-037 Flush in 4th BUSY cycle -> no writes; mul_start_o low next cycle; REL then IDLE.
REQ-038 Back-to-back MULT, and MTHI 0x1234 on the commit edge -> second op starts after one REL cycle; HI = product high word, not 0x1234.
REQ-039 resetn pulsed low mid-BUSY -> all outputs 0 at once; next MULTU 2 x 3 -> LO = 6.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Bundles the EX-stage, HI/LO, multiplier and GPR write-back signals of the multiply controller.
// The slave modport is the controller's view; the master modport is the surrounding pipeline's view.
interface mul_ctrl_if;
    logic        ex_mul_valid;
    logic        ex_mul_sign;
    logic        ex_mul_to_gpr;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [4:0]  ex_dest;
    logic        flush;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] hilo_wdata_i;
    logic        mul_start_o;
    logic        mul_sign_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic        mul_ready_i;
    logic [63:0] mul_result_i;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o;

    modport slave (
        input  ex_mul_valid, ex_mul_sign, ex_mul_to_gpr, ex_src1, ex_src2, ex_dest,
        input  flush, hi_we_i, lo_we_i, hilo_wdata_i, mul_ready_i, mul_result_i,
        output mul_start_o, mul_sign_o, mul_op1_o, mul_op2_o, stall_o,
        output hi_o, lo_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o
    );

    modport master (
        output ex_mul_valid, ex_mul_sign, ex_mul_to_gpr, ex_src1, ex_src2, ex_dest,
        output flush, hi_we_i, lo_we_i, hilo_wdata_i, mul_ready_i, mul_result_i,
        input  mul_start_o, mul_sign_o, mul_op1_o, mul_op2_o, stall_o,
        input  hi_o, lo_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o
    );
endinterface

// File: rtl/mul_ctrl.sv
// Multiply controller: holds EX while an external multi-cycle multiplier runs, then commits
// the product to HI/LO or, for MUL, pulses a single GPR write of the low word.
module mul_ctrl (
    input  logic     clk,
    input  logic     resetn,
    mul_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, REL} state_t;

    state_t      r_state;
    logic        r_start;
    logic        r_sign;
    logic        r_toGpr;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [4:0]  r_dest;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_gprWe;
    logic [4:0]  r_gprWaddr;
    logic [31:0] r_gprWdata;
    logic        w_stall;

    // Stall is forced low while reset is asserted so a held EX instruction cannot freeze the pipe.
    always_comb begin
        w_stall = 1'b0;
        if (resetn) begin
            w_stall = ((r_state == IDLE) && bus.ex_mul_valid && !bus.flush) ||
                      ((r_state == BUSY) && !bus.mul_ready_i && !bus.flush) ||
                      ((r_state == REL)  && bus.ex_mul_valid);
        end
    end

    // MTHI/MTLO are applied first so a same-edge product commit overrides them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_sign     <= 1'b0;
            r_toGpr    <= 1'b0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_dest     <= 5'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_gprWe    <= 1'b0;
            r_gprWaddr <= 5'd0;
            r_gprWdata <= 32'd0;
        end else begin
            r_gprWe    <= 1'b0;
            r_gprWaddr <= 5'd0;
            r_gprWdata <= 32'd0;
            if (bus.hi_we_i) begin
                r_hi <= bus.hilo_wdata_i;
            end
            if (bus.lo_we_i) begin
                r_lo <= bus.hilo_wdata_i;
            end
            case (r_state)
                IDLE: begin
                    if (bus.ex_mul_valid && !bus.flush) begin
                        r_op1   <= bus.ex_src1;
                        r_op2   <= bus.ex_src2;
                        r_sign  <= bus.ex_mul_sign;
                        r_toGpr <= bus.ex_mul_to_gpr;
                        r_dest  <= bus.ex_dest;
                        r_start <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        r_start <= 1'b0;
                        r_state <= REL;
                    end else if (bus.mul_ready_i) begin
                        r_start <= 1'b0;
                        r_state <= REL;
                        if (r_toGpr) begin
                            if (r_dest != 5'd0) begin
                                r_gprWe    <= 1'b1;
                                r_gprWaddr <= r_dest;
                                r_gprWdata <= bus.mul_result_i[31:0];
                            end
                        end else begin
                            r_hi <= bus.mul_result_i[63:32];
                            r_lo <= bus.mul_result_i[31:0];
                        end
                    end
                end
                REL: begin
                    r_start <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mul_start_o = r_start;
    assign bus.mul_sign_o  = r_sign;
    assign bus.mul_op1_o   = r_op1;
    assign bus.mul_op2_o   = r_op2;
    assign bus.stall_o     = w_stall;
    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;
    assign bus.gpr_we_o    = r_gprWe;
    assign bus.gpr_waddr_o = r_gprWaddr;
    assign bus.gpr_wdata_o = r_gprWdata;

endmodule

// File: tb/tb_mul_ctrl.sv
// Testbench for mul_ctrl: a behavioural 8-cycle multiplier plus a table of directed multiplies,
// followed by hand-written flush, back-to-back/MTHI and mid-operation reset sequences.
module tb_mul_ctrl;

    typedef struct {
        logic        sign;
        logic        toGpr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expWe;
        logic [31:0] expWdata;
    } vec_t;

    logic        clk;
    logic        resetn;
    int          checks;
    int          failures;
    logic [3:0]  mulCnt;
    logic [63:0] prodU;
    logic [63:0] prodS;
    vec_t        vecs[8];

    mul_ctrl_if bus ();

    mul_ctrl dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: ready for one cycle, 7 edges after start is first seen high.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mulCnt <= 4'd0;
        end else if (!bus.mul_start_o) begin
            mulCnt <= 4'd0;
        end else if (mulCnt != 4'd15) begin
            mulCnt <= mulCnt + 4'd1;
        end
    end

    assign prodU = {32'd0, bus.mul_op1_o} * {32'd0, bus.mul_op2_o};
    assign prodS = {{32{bus.mul_op1_o[31]}}, bus.mul_op1_o} * {{32{bus.mul_op2_o[31]}}, bus.mul_op2_o};
    assign bus.mul_ready_i  = bus.mul_start_o && (mulCnt == 4'd7);
    assign bus.mul_result_i = bus.mul_ready_i ? (bus.mul_sign_o ? prodS : prodU) : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sign, input logic toGpr,
                                 input logic [31:0] src1, input logic [31:0] src2, input logic [4:0] dest);
        bus.ex_mul_valid  = valid;
        bus.ex_mul_sign   = sign;
        bus.ex_mul_to_gpr = toGpr;
        bus.ex_src1       = src1;
        bus.ex_src2       = src2;
        bus.ex_dest       = dest;
    endtask

    task automatic runOp(input vec_t v, input string tag);
        int cycles;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, v.sign, v.toGpr, v.src1, v.src2, v.dest);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.stall_o) break;
            cycles++;
            if (cycles == 4) begin
                checkOutput({tag, " start in busy"}, 32'(bus.mul_start_o), 32'd1);
                checkOutput({tag, " op1"}, bus.mul_op1_o, v.src1);
                checkOutput({tag, " op2"}, bus.mul_op2_o, v.src2);
                checkOutput({tag, " sign"}, 32'(bus.mul_sign_o), 32'(v.sign));
            end
        end
        checkOutput({tag, " stall cycles"}, 32'(cycles), 32'd8);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput({tag, " hi"}, bus.hi_o, v.expHi);
        checkOutput({tag, " lo"}, bus.lo_o, v.expLo);
        checkOutput({tag, " gpr_we"}, 32'(bus.gpr_we_o), 32'(v.expWe));
        checkOutput({tag, " gpr_waddr"}, 32'(bus.gpr_waddr_o), v.expWe ? 32'(v.dest) : 32'd0);
        checkOutput({tag, " gpr_wdata"}, bus.gpr_wdata_o, v.expWdata);
        checkOutput({tag, " start in rel"}, 32'(bus.mul_start_o), 32'd0);
        @(negedge clk);
        checkOutput({tag, " gpr_we after"}, 32'(bus.gpr_we_o), 32'd0);
        checkOutput({tag, " gpr_waddr after"}, 32'(bus.gpr_waddr_o), 32'd0);
        checkOutput({tag, " gpr_wdata after"}, bus.gpr_wdata_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        vec_t v;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0006, 5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 32'd42};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0006, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32'd0};
        vecs[4] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0001, 32'h0000_0000, 1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0,  32'h4000_0000, 32'h0000_0000, 1'b0, 32'd0};
        vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0002, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'd0};
        vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFB};

        bus.flush        = 1'b0;
        bus.hi_we_i      = 1'b0;
        bus.lo_we_i      = 1'b0;
        bus.hilo_wdata_i = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        resetn = 1'b0;
        #3;
        checkOutput("reset stall", 32'(bus.stall_o), 32'd0);
        checkOutput("reset start", 32'(bus.mul_start_o), 32'd0);
        checkOutput("reset op1", bus.mul_op1_o, 32'd0);
        checkOutput("reset hi", bus.hi_o, 32'd0);
        checkOutput("reset lo", bus.lo_o, 32'd0);
        checkOutput("reset gpr_we", 32'(bus.gpr_we_o), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush in the 4th BUSY cycle, then confirm REL ignores flush and IDLE honours it.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'h0000_0003, 5'd0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flush busy stall", 32'(bus.stall_o), 32'd0);
        checkOutput("flush busy start", 32'(bus.mul_start_o), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("flush rel start", 32'(bus.mul_start_o), 32'd0);
        checkOutput("flush rel hi", bus.hi_o, 32'hFFFF_FFFF);
        checkOutput("flush rel lo", bus.lo_o, 32'h0000_0000);
        bus.flush        = 1'b1;
        bus.ex_mul_valid = 1'b1;
        #1;
        checkOutput("rel stall ignores flush", 32'(bus.stall_o), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("idle stall under flush", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle flush blocks accept", 32'(bus.mul_start_o), 32'd0);
        bus.flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (10) @(negedge clk);
        checkOutput("flush no late hi", bus.hi_o, 32'hFFFF_FFFF);
        checkOutput("flush no late lo", bus.lo_o, 32'h0000_0000);
        checkOutput("flush no gpr write", 32'(bus.gpr_we_o), 32'd0);

        @(posedge clk);
        #1;
        bus.lo_we_i      = 1'b1;
        bus.hilo_wdata_i = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        bus.lo_we_i = 1'b0;
        checkOutput("mtlo lo", bus.lo_o, 32'h0000_CAFE);
        checkOutput("mtlo hi kept", bus.hi_o, 32'hFFFF_FFFF);

        // Back-to-back MULT with MTHI colliding with the first commit edge.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFE, 5'd0);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.stall_o) break;
            cycles++;
        end
        checkOutput("b2b first stall cycles", 32'(cycles), 32'd8);
        bus.hi_we_i      = 1'b1;
        bus.hilo_wdata_i = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.hi_we_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0005, 5'd0);
        @(negedge clk);
        checkOutput("b2b commit beats mthi", bus.hi_o, 32'hFFFF_FFFF);
        checkOutput("b2b first lo", bus.lo_o, 32'hFFFF_FFFA);
        checkOutput("b2b rel start", 32'(bus.mul_start_o), 32'd0);
        checkOutput("b2b rel stall", 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        checkOutput("b2b idle start", 32'(bus.mul_start_o), 32'd0);
        checkOutput("b2b idle stall", 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        checkOutput("b2b second start", 32'(bus.mul_start_o), 32'd1);
        checkOutput("b2b second op1", bus.mul_op1_o, 32'h0000_0004);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.stall_o) break;
            cycles++;
            @(negedge clk);
        end
        checkOutput("b2b second busy stall cycles", 32'(cycles), 32'd7);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("b2b second hi", bus.hi_o, 32'h0000_0000);
        checkOutput("b2b second lo", bus.lo_o, 32'h0000_0014);

        // Reset pulsed in the middle of a BUSY period.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 5'd0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midreset start", 32'(bus.mul_start_o), 32'd0);
        checkOutput("midreset sign", 32'(bus.mul_sign_o), 32'd0);
        checkOutput("midreset op1", bus.mul_op1_o, 32'd0);
        checkOutput("midreset op2", bus.mul_op2_o, 32'd0);
        checkOutput("midreset hi", bus.hi_o, 32'd0);
        checkOutput("midreset lo", bus.lo_o, 32'd0);
        checkOutput("midreset stall", 32'(bus.stall_o), 32'd0);
        checkOutput("midreset gpr_waddr", 32'(bus.gpr_waddr_o), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (12) @(negedge clk);
        checkOutput("midreset no commit lo", bus.lo_o, 32'd0);
        v = '{1'b0, 1'b0, 32'h0000_0002, 32'h0000_0003, 5'd0, 32'h0000_0000, 32'h0000_0006, 1'b0, 32'd0};
        runOp(v, "post-reset multu");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
